// File: rtl/wake_pkg.sv
// wake_pkg: shared types and constants for the UART wake manager.
//   state_e         - wake FSM states; encoding is visible on o_State for debug
//   GLITCH_COUNT_W  - width of the saturating rejected-edge counter
//   cnt_width()     - bits needed to hold a count of 0..max_count
package wake_pkg;

  typedef enum logic [2:0] {
    ST_AWAKE    = 3'd0,
    ST_SLEEP    = 3'd1,
    ST_DETECT   = 3'd2,
    ST_SETTLE   = 3'd3,
    ST_WAKE_REQ = 3'd4
  } state_e;

  localparam int GLITCH_COUNT_W = 8;
  localparam logic [GLITCH_COUNT_W-1:0] GLITCH_COUNT_MAX = 8'hFF;

  // Counters never wrap, so they must hold the terminal value itself.
  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/rx_sync.sv
// rx_sync: STAGES-flop synchroniser for an asynchronous, idle-high line.
// Flops reset to 1 so a line held in reset never looks like a start bit.
//   i_Clock  - sampling clock
//   i_reset  - synchronous active-high reset
//   i_async  - raw asynchronous input
//   o_sync   - synchronised output, STAGES cycles behind the pin
module rx_sync #(
  parameter int STAGES = 2
) (
  input  logic i_Clock,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] sync_r;

  // Shift chain: stage 0 samples the pin, the last stage is the output.
  always_ff @(posedge i_Clock) begin
    if (i_reset) begin
      sync_r <= {STAGES{1'b1}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], i_async};
    end
  end

  assign o_sync = sync_r[STAGES-1];

endmodule

// File: rtl/wake_manager.sv
// wake_manager: parks the UART in sleep and wakes it on a qualified RX start
// edge or on local activity, then restores clocks, waits for the clocks to
// settle and handshakes the wake with the system.
//   i_Clock, i_reset  - clock, synchronous active-high reset
//   i_Sleep           - sleep request level from the power manager
//   i_RX_Serial       - raw RX pin, idle high
//   i_Wake_Ack        - system acknowledge of o_Wake_Req
//   o_Clk_En          - UART datapath clock-gate enable
//   o_Rx_Enable       - UART receiver enable (only while fully awake)
//   o_Wake_Req        - wake request, held until ack or timeout
//   o_Timeout         - one-cycle pulse when the ack never came
//   o_Glitch_Count    - saturating count of rejected wake edges
//   o_State           - FSM state, for debug
module wake_manager
  import wake_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int GLITCH_CYCLES = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int ACK_TIMEOUT   = 1024
) (
  input  logic       i_Clock,
  input  logic       i_reset,
  input  logic       i_Sleep,
  input  logic       i_RX_Serial,
  input  logic       i_Wake_Ack,
  output logic       o_Clk_En,
  output logic       o_Rx_Enable,
  output logic       o_Wake_Req,
  output logic       o_Timeout,
  output logic [7:0] o_Glitch_Count,
  output logic [2:0] o_State
);

  localparam int GLITCH_W = cnt_width(GLITCH_CYCLES);
  localparam int SETTLE_W = cnt_width(SETTLE_CYCLES);
  localparam int ACK_W    = cnt_width(ACK_TIMEOUT);

  // Terminal compare values: the transition edge itself is the last counted cycle.
  localparam logic [GLITCH_W-1:0] GLITCH_LAST = GLITCH_W'(GLITCH_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GLITCH_ONE  = GLITCH_W'(1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
  localparam logic [ACK_W-1:0]    ACK_LAST    = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [ACK_W-1:0]    ACK_ONE     = ACK_W'(1);

  state_e                    state_r;
  logic                      armed_r;
  logic [GLITCH_W-1:0]       glitch_cnt_r;
  logic [SETTLE_W-1:0]       settle_cnt_r;
  logic [ACK_W-1:0]          ack_cnt_r;
  logic [GLITCH_COUNT_W-1:0] glitch_count_r;
  logic                      clk_en_r;
  logic                      rx_enable_r;
  logic                      wake_req_r;
  logic                      timeout_r;
  logic                      rx_s;

  rx_sync #(
    .STAGES (SYNC_STAGES)
  ) u_rx_sync (
    .i_Clock (i_Clock),
    .i_reset (i_reset),
    .i_async (i_RX_Serial),
    .o_sync  (rx_s)
  );

  // Wake FSM with its counters, armed flag and registered outputs.
  always_ff @(posedge i_Clock) begin
    if (i_reset) begin
      state_r        <= ST_AWAKE;
      armed_r        <= 1'b0;
      glitch_cnt_r   <= {GLITCH_W{1'b0}};
      settle_cnt_r   <= {SETTLE_W{1'b0}};
      ack_cnt_r      <= {ACK_W{1'b0}};
      glitch_count_r <= {GLITCH_COUNT_W{1'b0}};
      clk_en_r       <= 1'b1;
      rx_enable_r    <= 1'b1;
      wake_req_r     <= 1'b0;
      timeout_r      <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      // A low sleep level proves the power manager released the last request.
      if (!i_Sleep) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end

      case (state_r)
        ST_AWAKE: begin
          // Never gate the receiver while a byte is in flight.
          if (i_Sleep && armed_r && rx_s) begin
            state_r     <= ST_SLEEP;
            clk_en_r    <= 1'b0;
            rx_enable_r <= 1'b0;
          end else begin
            state_r <= ST_AWAKE;
          end
        end

        ST_SLEEP: begin
          // RX edge has priority over local wake so the edge is qualified.
          if (!rx_s) begin
            state_r      <= ST_DETECT;
            glitch_cnt_r <= GLITCH_ONE;
          end else if (!i_Sleep) begin
            state_r      <= ST_SETTLE;
            settle_cnt_r <= {SETTLE_W{1'b0}};
            clk_en_r     <= 1'b1;
          end else begin
            state_r <= ST_SLEEP;
          end
        end

        ST_DETECT: begin
          if (rx_s) begin
            state_r      <= ST_SLEEP;
            glitch_cnt_r <= {GLITCH_W{1'b0}};
            if (glitch_count_r != GLITCH_COUNT_MAX) begin
              glitch_count_r <= glitch_count_r + 8'd1;
            end else begin
              glitch_count_r <= glitch_count_r;
            end
          end else if (glitch_cnt_r >= GLITCH_LAST) begin
            state_r      <= ST_SETTLE;
            settle_cnt_r <= {SETTLE_W{1'b0}};
            clk_en_r     <= 1'b1;
          end else begin
            glitch_cnt_r <= glitch_cnt_r + GLITCH_ONE;
          end
        end

        ST_SETTLE: begin
          if (settle_cnt_r >= SETTLE_LAST) begin
            state_r    <= ST_WAKE_REQ;
            ack_cnt_r  <= {ACK_W{1'b0}};
            wake_req_r <= 1'b1;
            // Disarm unless the sleep request is already released this cycle.
            armed_r    <= ~i_Sleep;
          end else begin
            settle_cnt_r <= settle_cnt_r + SETTLE_ONE;
          end
        end

        ST_WAKE_REQ: begin
          if (i_Wake_Ack || (ack_cnt_r >= ACK_LAST)) begin
            state_r     <= ST_AWAKE;
            wake_req_r  <= 1'b0;
            rx_enable_r <= 1'b1;
            clk_en_r    <= 1'b1;
            // An ack on the last allowed cycle still wins over the timeout.
            timeout_r   <= ~i_Wake_Ack;
          end else begin
            ack_cnt_r <= ack_cnt_r + ACK_ONE;
          end
        end

        default: begin
          state_r     <= ST_AWAKE;
          clk_en_r    <= 1'b1;
          rx_enable_r <= 1'b1;
          wake_req_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_Clk_En       = clk_en_r;
  assign o_Rx_Enable    = rx_enable_r;
  assign o_Wake_Req     = wake_req_r;
  assign o_Timeout      = timeout_r;
  assign o_Glitch_Count = glitch_count_r;
  assign o_State        = state_r;

endmodule

// File: tb/tb_wake_manager.sv
// tb_wake_manager: table vectors, directed corner-case sequences and a
// randomized run, all cross-checked every cycle against a timestamp-based
// reference model of the wake rules.
module tb_wake_manager;

  localparam int SYNC    = 2;
  localparam int GLITCH  = 8;
  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sl  = 1'b0;
  logic       rx  = 1'b1;
  logic       ack = 1'b0;
  logic       o_Clk_En, o_Rx_Enable, o_Wake_Req, o_Timeout;
  logic [7:0] o_Glitch_Count;
  logic [2:0] o_State;

  int n_vec  = 0;
  int n_miss = 0;

  wake_manager #(
    .SYNC_STAGES   (SYNC),
    .GLITCH_CYCLES (GLITCH),
    .SETTLE_CYCLES (SETTLE),
    .ACK_TIMEOUT   (TIMEOUT)
  ) dut (
    .i_Clock        (clk),
    .i_reset        (rst),
    .i_Sleep        (sl),
    .i_RX_Serial    (rx),
    .i_Wake_Ack     (ack),
    .o_Clk_En       (o_Clk_En),
    .o_Rx_Enable    (o_Rx_Enable),
    .o_Wake_Req     (o_Wake_Req),
    .o_Timeout      (o_Timeout),
    .o_Glitch_Count (o_Glitch_Count),
    .o_State        (o_State)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Phases: 0 awake, 1 sleep, 2 detect, 3 settle, 4 wake request.
  // rx_s is the pin delayed through a queue; "armed" means some cycle with
  // sleep low happened at or after the last disarming point.
  int cyc = 0;
  int m_phase = 0, m_since = 0, m_low_run = 0, m_gc = 0;
  int m_last_low = -1, m_arm_floor = 0;
  bit m_timeout = 1'b0;
  bit m_q[$];

  task automatic model_edge();
    bit rxs;
    bit armed;
    int nxt;
    cyc++;
    if (rst) begin
      m_phase = 0; m_since = 0; m_low_run = 0; m_gc = 0; m_timeout = 1'b0;
      m_q.delete();
      for (int i = 0; i < SYNC; i++) m_q.push_back(1'b1);
      m_last_low  = -1;
      m_arm_floor = cyc + 1;
      return;
    end
    rxs = m_q.pop_front();
    m_q.push_back(rx);
    m_low_run = rxs ? 0 : m_low_run + 1;
    armed = (m_last_low >= m_arm_floor);
    m_timeout = 1'b0;
    nxt = m_phase;
    case (m_phase)
      0: if (sl && armed && rxs) nxt = 1;
      1: if (!rxs) nxt = 2; else if (!sl) nxt = 3;
      2: begin
        if (rxs) begin
          nxt = 1;
          if (m_gc < 255) m_gc++;
        end else if (m_low_run >= GLITCH) nxt = 3;
      end
      3: if (m_since + 1 >= SETTLE) begin nxt = 4; m_arm_floor = cyc; end
      4: begin
        if (ack) nxt = 0;
        else if (m_since + 1 >= TIMEOUT) begin nxt = 0; m_timeout = 1'b1; end
      end
      default: nxt = 0;
    endcase
    if (!sl) m_last_low = cyc;
    m_since = (nxt != m_phase) ? 0 : m_since + 1;
    m_phase = nxt;
  endtask

  // Model advances on every edge with the inputs present at that edge.
  always @(posedge clk) begin
    model_edge();
    #2;
    chk("model_state",   16'(o_State), 16'(m_phase));
    chk("model_clk_en",  16'(o_Clk_En), 16'(!(m_phase == 1 || m_phase == 2)));
    chk("model_rx_en",   16'(o_Rx_Enable), 16'(m_phase == 0));
    chk("model_req",     16'(o_Wake_Req), 16'(m_phase == 4));
    chk("model_timeout", 16'(o_Timeout), 16'(m_timeout));
    chk("model_gcount",  16'(o_Glitch_Count), 16'(m_gc));
  end

  // ---------------- directed helpers ----------------
  task automatic do_reset();
    rst = 1'b1; sl = 1'b0; rx = 1'b1; ack = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic go_sleep();
    sl = 1'b0; tick(); tick();
    sl = 1'b1; tick();
    chk("sleep_entry", 16'(o_State), 16'd1);
  endtask

  // Ten low cycles at the pin: 2 synchroniser + 8 qualification cycles.
  task automatic to_settle();
    rx = 1'b0;
    repeat (10) tick();
    rx = 1'b1;
    chk("to_settle", 16'(o_State), 16'd3);
  endtask

  typedef struct {
    logic       rst, sl, rx, ack;
    logic [2:0] st;
    logic       clk_en, rx_en, req;
    logic [7:0] gc;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int n;
    int rrun;

    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 8'd1};

    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst; sl = tbl[i].sl; rx = tbl[i].rx; ack = tbl[i].ack;
      tick();
      chk($sformatf("tbl%0d_state", i),  16'(o_State), 16'(tbl[i].st));
      chk($sformatf("tbl%0d_clk_en", i), 16'(o_Clk_En), 16'(tbl[i].clk_en));
      chk($sformatf("tbl%0d_rx_en", i),  16'(o_Rx_Enable), 16'(tbl[i].rx_en));
      chk($sformatf("tbl%0d_req", i),    16'(o_Wake_Req), 16'(tbl[i].req));
      chk($sformatf("tbl%0d_gcount", i), 16'(o_Glitch_Count), 16'(tbl[i].gc));
    end
    ack = 1'b0;

    // Valid wake with exact latencies.
    do_reset();
    go_sleep();
    chk("sleep_clk_en", 16'(o_Clk_En), 16'd0);
    chk("sleep_rx_en", 16'(o_Rx_Enable), 16'd0);
    rx = 1'b0;
    repeat (9) tick();
    chk("wake_detect_9", 16'(o_State), 16'd2);
    tick();
    chk("wake_settle_10", 16'(o_State), 16'd3);
    chk("wake_settle_clk_en", 16'(o_Clk_En), 16'd1);
    chk("wake_settle_rx_en", 16'(o_Rx_Enable), 16'd0);
    repeat (2) tick();
    rx = 1'b1;
    repeat (13) tick();
    chk("settle_15", 16'(o_State), 16'd3);
    chk("settle_15_req", 16'(o_Wake_Req), 16'd0);
    tick();
    chk("settle_16_state", 16'(o_State), 16'd4);
    chk("settle_16_req", 16'(o_Wake_Req), 16'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_state", 16'(o_State), 16'd0);
    chk("ack_req", 16'(o_Wake_Req), 16'd0);
    chk("ack_rx_en", 16'(o_Rx_Enable), 16'd1);
    chk("ack_gcount", 16'(o_Glitch_Count), 16'd0);

    // Glitch rejection and saturation.
    do_reset();
    go_sleep();
    for (int i = 0; i < 300; i++) begin
      rx = 1'b0; repeat (5) tick();
      rx = 1'b1; repeat (4) tick();
      if (i == 0) begin
        chk("glitch_first_count", 16'(o_Glitch_Count), 16'd1);
        chk("glitch_first_state", 16'(o_State), 16'd1);
      end
    end
    chk("glitch_saturated", 16'(o_Glitch_Count), 16'd255);
    chk("glitch_sat_state", 16'(o_State), 16'd1);

    // Ack timeout, then no re-sleep until the sleep level toggles.
    do_reset();
    go_sleep();
    to_settle();
    n = 0;
    while (o_Wake_Req !== 1'b1 && n < 40) begin tick(); n++; end
    chk("settle_length", 16'(n), 16'd16);
    n = 0;
    while (o_Timeout !== 1'b1 && n < 1100) begin tick(); n++; end
    chk("timeout_delay", 16'(n), 16'd1024);
    chk("timeout_state", 16'(o_State), 16'd0);
    chk("timeout_req", 16'(o_Wake_Req), 16'd0);
    tick();
    chk("timeout_one_cycle", 16'(o_Timeout), 16'd0);
    repeat (5) tick();
    chk("no_resleep_held", 16'(o_State), 16'd0);
    sl = 1'b0; tick();
    sl = 1'b1; tick();
    chk("resleep_after_toggle", 16'(o_State), 16'd1);

    // Ack on the timeout cycle counts as an ack.
    to_settle();
    n = 0;
    while (o_Wake_Req !== 1'b1 && n < 40) begin tick(); n++; end
    repeat (TIMEOUT - 1) tick();
    chk("late_ack_still_req", 16'(o_Wake_Req), 16'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("late_ack_state", 16'(o_State), 16'd0);
    chk("late_ack_no_timeout", 16'(o_Timeout), 16'd0);

    // Local wake, and RX winning a same-cycle collision.
    do_reset();
    go_sleep();
    sl = 1'b0; tick();
    chk("local_wake", 16'(o_State), 16'd3);
    do_reset();
    go_sleep();
    rx = 1'b0; tick(); tick();
    chk("collision_pre", 16'(o_State), 16'd1);
    sl = 1'b0; tick();
    chk("collision_rx_wins", 16'(o_State), 16'd2);
    sl = 1'b1; rx = 1'b1;

    // Reset mid-sequence in SETTLE and in WAKE_REQ.
    do_reset();
    go_sleep();
    rx = 1'b0; repeat (5) tick();
    rx = 1'b1; repeat (4) tick();
    chk("mid_glitch", 16'(o_Glitch_Count), 16'd1);
    to_settle();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_settle_state", 16'(o_State), 16'd0);
    chk("rst_settle_clk_en", 16'(o_Clk_En), 16'd1);
    chk("rst_settle_req", 16'(o_Wake_Req), 16'd0);
    chk("rst_settle_gcount", 16'(o_Glitch_Count), 16'd0);
    go_sleep();
    to_settle();
    repeat (16) tick();
    chk("pre_rst_wakereq", 16'(o_State), 16'd4);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_wakereq_state", 16'(o_State), 16'd0);
    chk("rst_wakereq_req", 16'(o_Wake_Req), 16'd0);
    chk("rst_wakereq_clk_en", 16'(o_Clk_En), 16'd1);
    go_sleep();
    to_settle();
    repeat (15) tick();
    chk("fresh_settle_15", 16'(o_State), 16'd3);
    tick();
    chk("fresh_settle_16", 16'(o_State), 16'd4);

    // Randomized traffic; the model checks every cycle.
    rrun = 0;
    for (int c = 0; c < 4000; c++) begin
      if (rrun == 0) begin
        rx = ~rx;
        rrun = rx ? int'($urandom_range(1, 25)) : int'($urandom_range(1, 14));
      end
      rrun--;
      sl  = ($urandom_range(0, 15) != 0);
      ack = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
